// File: rtl/seq_controller_pkg.sv
// ============================================================================
// seq_controller_pkg : shared states, status codes and icode sets
// Revision 1.0
// ============================================================================
`default_nettype none

package seq_controller_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_FETCH   = 3'd1;
    localparam state_t c_ST_DECODE  = 3'd2;
    localparam state_t c_ST_EXECUTE = 3'd3;
    localparam state_t c_ST_MEMORY  = 3'd4;
    localparam state_t c_ST_WB      = 3'd5;
    localparam state_t c_ST_PCUPD   = 3'd6;
    localparam state_t c_ST_HALT    = 3'd7;

    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    localparam logic [3:0] c_IC_HALT   = 4'h0;
    localparam logic [3:0] c_IC_NOP    = 4'h1;
    localparam logic [3:0] c_IC_RRMOVQ = 4'h2;
    localparam logic [3:0] c_IC_IRMOVQ = 4'h3;
    localparam logic [3:0] c_IC_RMMOVQ = 4'h4;
    localparam logic [3:0] c_IC_MRMOVQ = 4'h5;
    localparam logic [3:0] c_IC_OPQ    = 4'h6;
    localparam logic [3:0] c_IC_JXX    = 4'h7;
    localparam logic [3:0] c_IC_CALL   = 4'h8;
    localparam logic [3:0] c_IC_RET    = 4'h9;
    localparam logic [3:0] c_IC_PUSHQ  = 4'hA;
    localparam logic [3:0] c_IC_POPQ   = 4'hB;

    // Instructions that touch data memory in the MEMORY stage.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == c_IC_RMMOVQ) || (ic == c_IC_MRMOVQ) || (ic == c_IC_CALL) ||
               (ic == c_IC_RET)    || (ic == c_IC_PUSHQ)  || (ic == c_IC_POPQ);
    endfunction

    // Instructions that write the register file in WRITEBACK.
    function automatic logic is_wb_icode(input logic [3:0] ic);
        return (ic == c_IC_RRMOVQ) || (ic == c_IC_IRMOVQ) || (ic == c_IC_MRMOVQ) ||
               (ic == c_IC_OPQ)    || (ic == c_IC_CALL)   || (ic == c_IC_RET)    ||
               (ic == c_IC_PUSHQ)  || (ic == c_IC_POPQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_controller_mem_wait_timer.sv
// ============================================================================
// mem_wait_timer : clear/increment wait counter with timeout flag
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int c_CW = $clog2(MEM_TIMEOUT + 1);

    logic [c_CW-1:0] count_q;
    logic [c_CW-1:0] count_d;

    assign timeout_o = (count_q == c_CW'(MEM_TIMEOUT));

    // Saturates at the limit so the flag stays up until cleared.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !timeout_o) begin
            count_d = count_q + c_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_controller.sv
// ============================================================================
// seq_controller : multi-cycle Y86-style stage sequencer with fault handling
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_controller
    import seq_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [3:0]  icode_i,
    input  logic        imem_error_i,
    input  logic        mem_ready_i,
    input  logic        dmem_error_i,
    output logic        fetch_en_o,
    output logic        decode_en_o,
    output logic        execute_en_o,
    output logic        memory_en_o,
    output logic        wb_en_o,
    output logic        pc_en_o,
    output logic        mem_req_o,
    output logic [2:0]  stat_o,
    output logic        busy_o,
    output logic [31:0] instr_count_o
);

    state_t      state_q, state_d;
    logic [3:0]  icode_q, icode_d;
    logic [2:0]  stat_q, stat_d;
    logic [31:0] count_q, count_d;

    logic w_in_mem;
    logic w_outstanding;
    logic w_timeout;

    assign w_in_mem      = (state_q == c_ST_MEMORY);
    // A request is live only in MEMORY for a memory icode that has not timed out.
    assign w_outstanding = w_in_mem && is_mem_icode(icode_q) && !w_timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!w_in_mem),
        .inc_i     (w_outstanding && !mem_ready_i),
        .timeout_o (w_timeout)
    );

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        stat_d  = stat_q;
        count_d = count_q;
        case (state_q)
            c_ST_IDLE: begin
                if (start_i) state_d = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (imem_error_i) begin
                    stat_d  = c_STAT_ADR;
                    state_d = c_ST_HALT;
                end else if (icode_i > c_IC_POPQ) begin
                    stat_d  = c_STAT_INS;
                    state_d = c_ST_HALT;
                end else if (icode_i == c_IC_HALT) begin
                    stat_d  = c_STAT_HLT;
                    state_d = c_ST_HALT;
                end else begin
                    icode_d = icode_i;
                    state_d = c_ST_DECODE;
                end
            end
            c_ST_DECODE:  state_d = c_ST_EXECUTE;
            c_ST_EXECUTE: state_d = c_ST_MEMORY;
            c_ST_MEMORY: begin
                if (!is_mem_icode(icode_q)) begin
                    state_d = c_ST_WB;
                end else if (w_timeout) begin
                    stat_d  = c_STAT_ADR;
                    state_d = c_ST_HALT;
                end else if (mem_ready_i) begin
                    if (dmem_error_i) begin
                        stat_d  = c_STAT_ADR;
                        state_d = c_ST_HALT;
                    end else begin
                        state_d = c_ST_WB;
                    end
                end
            end
            c_ST_WB: state_d = c_ST_PCUPD;
            c_ST_PCUPD: begin
                count_d = count_q + 32'd1;
                state_d = c_ST_FETCH;
            end
            c_ST_HALT: state_d = c_ST_HALT;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            icode_q <= c_IC_NOP;
            stat_q  <= c_STAT_AOK;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            stat_q  <= stat_d;
            count_q <= count_d;
        end
    end

    assign fetch_en_o    = (state_q == c_ST_FETCH);
    assign decode_en_o   = (state_q == c_ST_DECODE);
    assign execute_en_o  = (state_q == c_ST_EXECUTE);
    assign memory_en_o   = w_in_mem;
    assign wb_en_o       = (state_q == c_ST_WB) && is_wb_icode(icode_q);
    assign pc_en_o       = (state_q == c_ST_PCUPD);
    // Request drops in the same cycle the completion is seen.
    assign mem_req_o     = w_outstanding && !mem_ready_i;
    assign stat_o        = stat_q;
    assign busy_o        = (state_q != c_ST_IDLE) && (state_q != c_ST_HALT);
    assign instr_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_controller.sv
// ============================================================================
// tb_seq_controller : directed scoreboard bench for seq_controller
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_controller;

    localparam logic [5:0] c_E_0 = 6'b000000;
    localparam logic [5:0] c_E_F = 6'b100000;
    localparam logic [5:0] c_E_D = 6'b010000;
    localparam logic [5:0] c_E_X = 6'b001000;
    localparam logic [5:0] c_E_M = 6'b000100;
    localparam logic [5:0] c_E_W = 6'b000010;
    localparam logic [5:0] c_E_P = 6'b000001;

    localparam logic [2:0] c_AOK = 3'd1;
    localparam logic [2:0] c_HLT = 3'd2;
    localparam logic [2:0] c_ADR = 3'd3;
    localparam logic [2:0] c_INS = 3'd4;

    typedef struct packed {
        logic [5:0]  en;
        logic        mreq;
        logic [2:0]  stat;
        logic        busy;
        logic [31:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic        imem_error = 1'b0;
    logic        mem_ready = 1'b0;
    logic        dmem_error = 1'b0;
    logic        fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en;
    logic        mem_req;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] instr_count;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_controller #(.MEM_TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .icode_i       (icode),
        .imem_error_i  (imem_error),
        .mem_ready_i   (mem_ready),
        .dmem_error_i  (dmem_error),
        .fetch_en_o    (fetch_en),
        .decode_en_o   (decode_en),
        .execute_en_o  (execute_en),
        .memory_en_o   (memory_en),
        .wb_en_o       (wb_en),
        .pc_en_o       (pc_en),
        .mem_req_o     (mem_req),
        .stat_o        (stat),
        .busy_o        (busy),
        .instr_count_o (instr_count)
    );

    // Drive one cycle of inputs, queue the outputs expected in that cycle,
    // compare them at the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic r, input logic st, input logic [3:0] ic,
                       input logic ie, input logic mr, input logic de,
                       input logic [5:0] en, input logic mq, input logic [2:0] sx,
                       input logic bz, input logic [31:0] cn);
        obs_t e;
        obs_t got;
        rst        = r;
        start      = st;
        icode      = ic;
        imem_error = ie;
        mem_ready  = mr;
        dmem_error = de;
        exp_q.push_back('{en: en, mreq: mq, stat: sx, busy: bz, cnt: cn});
        @(negedge clk);
        got = '{en: {fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en},
                mreq: mem_req, stat: stat, busy: busy, cnt: instr_count};
        e = exp_q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s: observed en=%b req=%b stat=%0d busy=%b cnt=%0d expected en=%b req=%b stat=%0d busy=%b cnt=%0d",
                   tag, got.en, got.mreq, got.stat, got.busy, got.cnt,
                   e.en, e.mreq, e.stat, e.busy, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input string tag, input logic r, input logic st, input logic [2:0] sx,
                             input logic [5:0] en, input logic bz, input logic [31:0] cn);
        cyc(tag, r, st, 4'h1, 1'b0, 1'b0, 1'b0, en, 1'b0, sx, bz, cn);
    endtask

    // Non-memory instruction body after FETCH: D, X, M, W, P.
    task automatic plain_body(input string tag, input logic [5:0] wb, input logic [31:0] cn);
        cyc({tag, "_dec"}, 0, 0, 4'h1, 0, 0, 0, c_E_D, 0, c_AOK, 1, cn);
        cyc({tag, "_exe"}, 0, 0, 4'h1, 0, 0, 0, c_E_X, 0, c_AOK, 1, cn);
        cyc({tag, "_mem"}, 0, 0, 4'h1, 0, 1, 1, c_E_M, 0, c_AOK, 1, cn);
        cyc({tag, "_wb"},  0, 0, 4'h1, 0, 0, 0, wb,    0, c_AOK, 1, cn);
        cyc({tag, "_pc"},  0, 0, 4'h1, 0, 0, 0, c_E_P, 0, c_AOK, 1, cn);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state, then two OPq and a halt instruction.
        idle_step("rst", 1, 0, c_AOK, c_E_0, 0, 0);
        idle_step("idle_start", 0, 1, c_AOK, c_E_0, 0, 0);
        cyc("opq1_fetch", 0, 0, 4'h6, 0, 0, 0, c_E_F, 0, c_AOK, 1, 0);
        plain_body("opq1", c_E_W, 0);
        cyc("opq2_fetch", 0, 0, 4'h6, 0, 0, 0, c_E_F, 0, c_AOK, 1, 1);
        plain_body("opq2", c_E_W, 1);
        cyc("halt_fetch", 0, 0, 4'h0, 0, 0, 0, c_E_F, 0, c_AOK, 1, 2);
        idle_step("halt_hlt", 0, 0, c_HLT, c_E_0, 0, 2);
        idle_step("halt_start", 0, 1, c_HLT, c_E_0, 0, 2);
        idle_step("halt_sticky", 0, 0, c_HLT, c_E_0, 0, 2);

        // mrmovq with three wait cycles.
        idle_step("rst2", 1, 0, c_AOK, c_E_0, 0, 0);
        idle_step("mr_start", 0, 1, c_AOK, c_E_0, 0, 0);
        cyc("mr_fetch", 0, 0, 4'h5, 0, 0, 0, c_E_F, 0, c_AOK, 1, 0);
        cyc("mr_dec",   0, 0, 4'h1, 0, 0, 0, c_E_D, 0, c_AOK, 1, 0);
        cyc("mr_exe",   0, 0, 4'h1, 0, 0, 0, c_E_X, 0, c_AOK, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc("mr_wait", 0, 0, 4'h1, 0, 0, 0, c_E_M, 1, c_AOK, 1, 0);
        cyc("mr_ready", 0, 0, 4'h1, 0, 1, 0, c_E_M, 0, c_AOK, 1, 0);
        cyc("mr_wb",    0, 0, 4'h1, 0, 0, 0, c_E_W, 0, c_AOK, 1, 0);
        cyc("mr_pc",    0, 0, 4'h1, 0, 0, 0, c_E_P, 0, c_AOK, 1, 0);
        cyc("mr_next",  0, 0, 4'h1, 1, 0, 0, c_E_F, 0, c_AOK, 1, 1);
        idle_step("imem_adr", 0, 0, c_ADR, c_E_0, 0, 1);

        // rmmovq with a data-memory fault.
        idle_step("rst3", 1, 0, c_AOK, c_E_0, 0, 0);
        idle_step("rm_start", 0, 1, c_AOK, c_E_0, 0, 0);
        cyc("rm_fetch", 0, 0, 4'h4, 0, 0, 0, c_E_F, 0, c_AOK, 1, 0);
        cyc("rm_dec",   0, 0, 4'h1, 0, 0, 0, c_E_D, 0, c_AOK, 1, 0);
        cyc("rm_exe",   0, 0, 4'h1, 0, 0, 0, c_E_X, 0, c_AOK, 1, 0);
        cyc("rm_err",   0, 0, 4'h1, 0, 1, 1, c_E_M, 0, c_AOK, 1, 0);
        idle_step("rm_halt", 0, 0, c_ADR, c_E_0, 0, 0);
        idle_step("rm_sticky", 0, 0, c_ADR, c_E_0, 0, 0);

        // jXX: stray mem_ready ignored, no writeback; then an illegal icode.
        idle_step("rst4", 1, 0, c_AOK, c_E_0, 0, 0);
        idle_step("j_start", 0, 1, c_AOK, c_E_0, 0, 0);
        cyc("j_fetch", 0, 0, 4'h7, 0, 0, 0, c_E_F, 0, c_AOK, 1, 0);
        plain_body("jxx", c_E_0, 0);
        cyc("ins_fetch", 0, 0, 4'hC, 0, 0, 0, c_E_F, 0, c_AOK, 1, 1);
        idle_step("ins_halt", 0, 0, c_INS, c_E_0, 0, 1);

        // call with mem_ready never arriving.
        idle_step("rst5", 1, 0, c_AOK, c_E_0, 0, 0);
        idle_step("to_start", 0, 1, c_AOK, c_E_0, 0, 0);
        cyc("to_fetch", 0, 0, 4'h8, 0, 0, 0, c_E_F, 0, c_AOK, 1, 0);
        cyc("to_dec",   0, 0, 4'h1, 0, 0, 0, c_E_D, 0, c_AOK, 1, 0);
        cyc("to_exe",   0, 0, 4'h1, 0, 0, 0, c_E_X, 0, c_AOK, 1, 0);
        for (int i = 0; i < 15; i++)
            cyc("to_wait", 0, 0, 4'h1, 0, 0, 0, c_E_M, 1, c_AOK, 1, 0);
        cyc("to_expire", 0, 0, 4'h1, 0, 0, 0, c_E_M, 0, c_AOK, 1, 0);
        idle_step("to_halt", 0, 0, c_ADR, c_E_0, 0, 0);

        // Reset during a memory wait after one retired instruction.
        idle_step("rst6", 1, 0, c_AOK, c_E_0, 0, 0);
        idle_step("ab_start", 0, 1, c_AOK, c_E_0, 0, 0);
        cyc("ab_opq", 0, 0, 4'h6, 0, 0, 0, c_E_F, 0, c_AOK, 1, 0);
        plain_body("ab_opq", c_E_W, 0);
        cyc("ab_fetch", 0, 0, 4'h5, 0, 0, 0, c_E_F, 0, c_AOK, 1, 1);
        cyc("ab_dec",   0, 0, 4'h1, 0, 0, 0, c_E_D, 0, c_AOK, 1, 1);
        cyc("ab_exe",   0, 0, 4'h1, 0, 0, 0, c_E_X, 0, c_AOK, 1, 1);
        cyc("ab_wait",  0, 0, 4'h1, 0, 0, 0, c_E_M, 1, c_AOK, 1, 1);
        cyc("ab_wait",  0, 0, 4'h1, 0, 0, 0, c_E_M, 1, c_AOK, 1, 1);
        cyc("ab_rst",   1, 0, 4'h1, 0, 0, 0, c_E_0, 0, c_AOK, 0, 0);
        idle_step("ab_idle", 0, 0, c_AOK, c_E_0, 0, 0);
        idle_step("ab_idle2", 0, 0, c_AOK, c_E_0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max data-memory wait cycles before an address fault is declared.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins execution from IDLE.
REQ-005 icode  input  4  instruction code from fetch; sampled at end of FETCH.
REQ-006 imem_error  input  1  instruction-memory fault; sampled at end of FETCH.
REQ-007 mem_ready  input  1  data-memory completion handshake.
REQ-008 dmem_error  input  1  data-memory fault; qualified by mem_ready.
REQ-009 fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  output  1 each  one-hot stage enables to the datapath.
REQ-010 mem_req  output  1  data-memory request; held high while waiting.
REQ-011 stat  output  3  processor status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-012 busy  output  1  high in every state except IDLE and HALT.
REQ-013 instr_count  output  32  count of retired instructions.

Function
REQ-014 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; the stage enable matching the current state is high and all other enables are low.
REQ-015 IDLE->FETCH on start; start in any other state is ignored.
REQ-016 FETCH: imem_error -> stat=ADR, HALT; else icode>4'hB -> stat=INS, HALT; else icode=4'h0 -> stat=HLT, HALT; else latch icode, DECODE.
REQ-017 DECODE->EXECUTE->MEMORY unconditionally, one cycle each.
REQ-018 MEMORY, latched icode in {4,5,8,9,A,B}: mem_req high from MEMORY entry until the cycle mem_ready is sampled high; on that cycle go to WRITEBACK, or to HALT with stat=ADR if dmem_error is also high.
REQ-019 MEMORY, any other icode: mem_req stays low and the state advances to WRITEBACK after one cycle.
REQ-020 Wait counter clears on MEMORY entry and increments each waiting cycle; if MEM_TIMEOUT waiting cycles pass without mem_ready: stat=ADR, HALT, mem_req drops.
REQ-021 WRITEBACK: wb_en high only for latched icode in {2,3,5,6,8,9,A,B}; for 4 and 7, wb_en stays low while the state still occupies one cycle.
REQ-022 PCUPD: pc_en high; instr_count increments by 1 (wraps at 2^32-1 -> 0); next state FETCH.
REQ-023 Latency: a non-memory instruction takes 6 cycles FETCH through PCUPD; a memory instruction takes 6 cycles plus its wait cycles.
REQ-024 HALT is sticky until rst: all enables and mem_req are low, stat holds its fault code, and instr_count is frozen.
REQ-025 Faulting and halt instructions do not increment instr_count and never assert wb_en or pc_en.
REQ-026 If mem_ready arrives while no request is outstanding, it is ignored.

Reset
REQ-027 While rst is high: state=IDLE, all enables=0, mem_req=0, stat=AOK, busy=0, instr_count=0, wait counter=0, latched icode=4'h1.
REQ-028 rst asserted mid-instruction, including during a memory wait, aborts the instruction immediately with no wb_en or pc_en pulse.

Structure
REQ-029 The shared package holds the state enumeration, the stat codes (AOK/HLT/ADR/INS), the icode constants 0x0-0xB and the memory-access and register-write icode sets.
REQ-030 The one sub-module is mem_wait_timer: a clear/increment counter that raises a timeout flag at MEM_TIMEOUT.

Verification
REQ-031 rst, start, icode=6 (OPq), no errors -> enables go fetch..pc in 6 consecutive cycles, wb_en=1, mem_req=0, instr_count=1, next state FETCH.
REQ-032 icode=5 (mrmovq), mem_ready after 3 wait cycles -> mem_req high for exactly 3 cycles, then wb_en=1, instr_count=1, 9 cycles total.
REQ-033 icode=4 (rmmovq), mem_ready=1 with dmem_error=1 -> stat=ADR, HALT, wb_en and pc_en never high, instr_count unchanged.
REQ-034 icode=0 after 2 retired OPq -> stat=HLT, busy=0, instr_count=2, a later start pulse is ignored.
REQ-035 icode=4'hC -> stat=INS; icode=8 with mem_ready held low -> stat=ADR after 15 wait cycles.
REQ-036 rst pulsed during a MEMORY wait -> IDLE next edge, stat=AOK, instr_count=0, no wb_en pulse.
